enemy_target: RTL and testbench

Target-side counterpart to the player's bullet: a vertically patrolling enemy sprite that detects bullet overlap, consumes the bullet with a one-frame `bullet_hit` pulse, and tracks hit points, hit-flash, death, respawn and a kill score. It is clocked once per video frame, alongside the bullet and ball motion logic. It feeds position, size and visibility to the color mapper, and `bullet_hit` back to the bullet logic so the bullet retires.

---
 rtl/enemy_pkg.sv | 33 +++
 rtl/box_overlap.sv | 25 ++
 rtl/enemy_target.sv | 142 ++++++++++++++
 tb/tb_enemy_target.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy target and its collision helper.
package enemy_pkg;

  typedef enum logic [1:0] {ALIVE, FLASH, DEAD} enemy_state_t;

  localparam int unsigned CoordW = 10;

  localparam int unsigned ScreenXMin = 0;
  localparam int unsigned ScreenXMax = 639;
  localparam int unsigned ScreenYMin = 0;
  localparam int unsigned ScreenYMax = 479;

  localparam int unsigned EnemyXStart   = 480;
  localparam int unsigned EnemyYStart   = 240;
  localparam int unsigned EnemyYMin     = ScreenYMin;
  localparam int unsigned EnemyYMax     = ScreenYMax;
  localparam int unsigned EnemyYStep    = 2;
  localparam int unsigned EnemySize     = 8;
  localparam int unsigned HitPoints     = 3;
  localparam int unsigned FlashFrames   = 8;
  localparam int unsigned RespawnFrames = 60;

  localparam int unsigned TimerW = 6;
  localparam int unsigned HpW    = 2;

  // One bit wider than a coordinate so the magnitude never wraps.
  function automatic logic [CoordW:0] abs_diff(input logic [CoordW-1:0] a,
                                               input logic [CoordW-1:0] b);
    if (a >= b) return {1'b0, a} - {1'b0, b};
    else        return {1'b0, b} - {1'b0, a};
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap test on centres and half-sizes.
module box_overlap
  import enemy_pkg::*;
(
  input  logic [CoordW-1:0] a_x_i,
  input  logic [CoordW-1:0] a_y_i,
  input  logic [CoordW-1:0] a_s_i,
  input  logic [CoordW-1:0] b_x_i,
  input  logic [CoordW-1:0] b_y_i,
  input  logic [CoordW-1:0] b_s_i,
  input  logic              en_i,
  output logic              hit_o
);

  logic [CoordW:0] dx, dy, sum;

  always_comb begin
    dx    = abs_diff(a_x_i, b_x_i);
    dy    = abs_diff(a_y_i, b_y_i);
    sum   = {1'b0, a_s_i} + {1'b0, b_s_i};
    // Strict compare: boxes that only touch edges do not collide.
    hit_o = en_i && (dx < sum) && (dy < sum);
  end

endmodule

// File: rtl/enemy_target.sv
// Patrolling enemy: bullet hit detection, hit-flash, death/respawn and kill score.
// Define ENEMY_HEALTH_EN to enable the hit-point counter and the FLASH state.
module enemy_target
  import enemy_pkg::*;
(
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic [CoordW-1:0] BulletX,
  input  logic [CoordW-1:0] BulletY,
  input  logic [CoordW-1:0] BulletS,
  input  logic              bullet_on,
  output logic [CoordW-1:0] EnemyX,
  output logic [CoordW-1:0] EnemyY,
  output logic [CoordW-1:0] EnemyS,
  output logic              enemy_on,
  output logic              enemy_flash,
  output logic              bullet_hit,
  output logic [7:0]        Score
);

  enemy_state_t      state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CoordW-1:0] y_q, y_d;
  logic              down_q, down_d;
  logic              hit_q, hit_d;
  logic [7:0]        score_q, score_d;
  logic              on_q, flash_q;
  logic              overlap, hit_acc;
  logic [CoordW:0]   y_ext;
`ifdef ENEMY_HEALTH_EN
  logic [HpW-1:0]    hp_q, hp_d;
`endif

  assign EnemyX = CoordW'(EnemyXStart);
  assign EnemyS = CoordW'(EnemySize);

  box_overlap u_overlap (
    .a_x_i (BulletX),
    .a_y_i (BulletY),
    .a_s_i (BulletS),
    .b_x_i (EnemyX),
    .b_y_i (y_q),
    .b_s_i (EnemyS),
    .en_i  (bullet_on),
    .hit_o (overlap)
  );

  assign hit_acc = overlap && (state_q == ALIVE);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    score_d = score_q;
    hit_d   = 1'b0;
`ifdef ENEMY_HEALTH_EN
    hp_d    = hp_q;
`endif
    if (hit_acc) begin
      hit_d = 1'b1;
`ifdef ENEMY_HEALTH_EN
      if (hp_q == HpW'(1)) begin
        state_d = DEAD;
        timer_d = TimerW'(RespawnFrames - 1);
        hp_d    = HpW'(HitPoints);
        if (score_q != 8'hFF) score_d = score_q + 8'd1;
      end else begin
        state_d = FLASH;
        timer_d = TimerW'(FlashFrames - 1);
        hp_d    = hp_q - HpW'(1);
      end
`else
      state_d = DEAD;
      timer_d = TimerW'(RespawnFrames - 1);
      if (score_q != 8'hFF) score_d = score_q + 8'd1;
`endif
    end else if (state_q != ALIVE) begin
      if (timer_q == '0) state_d = ALIVE;
      else               timer_d = timer_q - TimerW'(1);
    end

    y_d    = y_q;
    down_d = down_q;
    y_ext  = {1'b0, y_q};
    if (state_q == DEAD) begin
      if (state_d == ALIVE) begin
        y_d    = CoordW'(EnemyYStart);
        down_d = 1'b1;
      end
    end else if (state_d != DEAD) begin
      if (y_ext + (CoordW+1)'(EnemySize) >= (CoordW+1)'(EnemyYMax)) begin
        down_d = 1'b0;
        y_d    = y_q - CoordW'(EnemyYStep);
      end else if (y_ext <= (CoordW+1)'(EnemyYMin + EnemySize)) begin
        down_d = 1'b1;
        y_d    = y_q + CoordW'(EnemyYStep);
      end else if (down_q) begin
        y_d    = y_q + CoordW'(EnemyYStep);
      end else begin
        y_d    = y_q - CoordW'(EnemyYStep);
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ALIVE;
      timer_q <= '0;
      y_q     <= CoordW'(EnemyYStart);
      down_q  <= 1'b1;
      hit_q   <= 1'b0;
      score_q <= 8'd0;
      on_q    <= 1'b1;
      flash_q <= 1'b0;
`ifdef ENEMY_HEALTH_EN
      hp_q    <= HpW'(HitPoints);
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      y_q     <= y_d;
      down_q  <= down_d;
      hit_q   <= hit_d;
      score_q <= score_d;
      on_q    <= (state_d != DEAD);
      flash_q <= (state_d == FLASH);
`ifdef ENEMY_HEALTH_EN
      hp_q    <= hp_d;
`endif
    end
  end

  assign EnemyY     = y_q;
  assign enemy_on   = on_q;
  assign bullet_hit = hit_q;
  assign Score      = score_q;
`ifdef ENEMY_HEALTH_EN
  assign enemy_flash = flash_q;
`else
  assign enemy_flash = 1'b0;
`endif

endmodule

// File: tb/tb_enemy_target.sv
// Scoreboard bench for enemy_target: directed stimulus queues frame-stamped expectations.
module tb_enemy_target;

  localparam int KY = 0, KX = 1, KON = 2, KFL = 3, KHIT = 4, KSC = 5, KS = 6;

  typedef struct {
    int at;
    int kind;
    int val;
  } exp_t;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] BulletX = '0, BulletY = '0, BulletS = '0;
  logic       bullet_on = 1'b0;
  logic [9:0] EnemyX, EnemyY, EnemyS;
  logic       enemy_on, enemy_flash, bullet_hit;
  logic [7:0] Score;

  int   frame = 0;
  int   checks = 0;
  int   failures = 0;
  bit   drain = 1'b0;
  exp_t q[$];

  enemy_target dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .BulletX     (BulletX),
    .BulletY     (BulletY),
    .BulletS     (BulletS),
    .bullet_on   (bullet_on),
    .EnemyX      (EnemyX),
    .EnemyY      (EnemyY),
    .EnemyS      (EnemyS),
    .enemy_on    (enemy_on),
    .enemy_flash (enemy_flash),
    .bullet_hit  (bullet_hit),
    .Score       (Score)
  );

  always #5 frame_clk = ~frame_clk;
  always @(posedge frame_clk) frame <= frame + 1;

  function automatic string kname(input int k);
    case (k)
      KY:      return "EnemyY";
      KX:      return "EnemyX";
      KON:     return "enemy_on";
      KFL:     return "enemy_flash";
      KHIT:    return "bullet_hit";
      KSC:     return "Score";
      default: return "EnemyS";
    endcase
  endfunction

  function automatic int actual(input int k);
    case (k)
      KY:      return int'(EnemyY);
      KX:      return int'(EnemyX);
      KON:     return int'(enemy_on);
      KFL:     return int'(enemy_flash);
      KHIT:    return int'(bullet_hit);
      KSC:     return int'(Score);
      default: return int'(EnemyS);
    endcase
  endfunction

  // Keep the queue ordered by frame so the monitor only looks at the head.
  task automatic expect_at(input int at, input int kind, input int val);
    exp_t e;
    int   i;
    e.at = at;
    e.kind = kind;
    e.val = val;
    i = q.size();
    while (i > 0 && q[i-1].at > at) i--;
    q.insert(i, e);
  endtask

  always @(negedge frame_clk) begin
    exp_t e;
    int   act;
    while (q.size() > 0 && (drain || q[0].at <= frame)) begin
      e = q.pop_front();
      checks++;
      if (e.at != frame) begin
        failures++;
        $display("FAIL %s frame=%0d not sampled (now %0d) expected=%0d",
                 kname(e.kind), e.at, frame, e.val);
      end else begin
        act = actual(e.kind);
        if (act != e.val) begin
          failures++;
          $display("FAIL %s frame=%0d got=%0d expected=%0d", kname(e.kind), e.at, act, e.val);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bullet_on = 1'b0;
    tick(1);
    Reset = 1'b0;
  endtask

  task automatic set_bullet(input int bx, input int by, input int bs, input bit on);
    BulletX = 10'(bx);
    BulletY = 10'(by);
    BulletS = 10'(bs);
    bullet_on = on;
  endtask

  // One-frame overlap probe with the enemy still at its reset position (480, 240).
  task automatic bnd(input int bx, input int by, input int bs, input bit on, input bit hit);
    int f;
    do_reset();
    f = frame;
    set_bullet(bx, by, bs, on);
    expect_at(f + 1, KHIT, int'(hit));
    if (hit) begin
`ifdef ENEMY_HEALTH_EN
      expect_at(f + 1, KFL, 1);
      expect_at(f + 1, KON, 1);
      expect_at(f + 1, KY, 242);
      expect_at(f + 1, KSC, 0);
`else
      expect_at(f + 1, KON, 0);
      expect_at(f + 1, KY, 240);
      expect_at(f + 1, KSC, 1);
      expect_at(f + 1, KFL, 0);
`endif
    end else begin
      expect_at(f + 1, KON, 1);
      expect_at(f + 1, KY, 242);
      expect_at(f + 1, KFL, 0);
    end
    tick(2);
  endtask

  initial begin
    int f;
    Reset = 1'b1;
    tick(2);

    // Reset values, then free patrol with bounces at both edges.
    do_reset();
    f = frame;
    expect_at(f, KX, 480);
    expect_at(f, KY, 240);
    expect_at(f, KON, 1);
    expect_at(f, KFL, 0);
    expect_at(f, KHIT, 0);
    expect_at(f, KSC, 0);
    expect_at(f, KS, 8);
    expect_at(f + 1, KY, 242);
    expect_at(f + 116, KY, 472);
    expect_at(f + 117, KY, 470);
    expect_at(f + 117, KX, 480);
    expect_at(f + 118, KY, 468);
    expect_at(f + 348, KY, 8);
    expect_at(f + 349, KY, 10);
    expect_at(f + 349, KX, 480);
    tick(350);

    bnd(468, 240, 4, 1'b1, 1'b0);
    bnd(469, 240, 4, 1'b1, 1'b1);
    bnd(469, 240, 4, 1'b0, 1'b0);
    bnd(491, 240, 4, 1'b1, 1'b1);
    bnd(492, 240, 4, 1'b1, 1'b0);
    bnd(480, 229, 4, 1'b1, 1'b1);
    bnd(480, 228, 4, 1'b1, 1'b0);

`ifdef ENEMY_HEALTH_EN
    // Bullet held 20 frames: one hit, eight flash frames, then the enemy drifts clear.
    do_reset();
    f = frame;
    set_bullet(478, 240, 4, 1'b1);
    expect_at(f + 1, KHIT, 1);
    expect_at(f + 1, KFL, 1);
    expect_at(f + 2, KHIT, 0);
    expect_at(f + 8, KFL, 1);
    expect_at(f + 9, KFL, 0);
    expect_at(f + 9, KHIT, 0);
    expect_at(f + 9, KY, 258);
    expect_at(f + 10, KHIT, 0);
    tick(20);
    bullet_on = 1'b0;
    tick(2);

    // Full-column bullet: three hits kill, respawn at start, then reset mid-flash.
    do_reset();
    f = frame;
    set_bullet(480, 240, 300, 1'b1);
    expect_at(f + 1, KHIT, 1);
    expect_at(f + 10, KHIT, 1);
    expect_at(f + 10, KFL, 1);
    expect_at(f + 18, KFL, 0);
    expect_at(f + 18, KSC, 0);
    expect_at(f + 19, KHIT, 1);
    expect_at(f + 19, KON, 0);
    expect_at(f + 19, KSC, 1);
    expect_at(f + 19, KY, 276);
    expect_at(f + 78, KON, 0);
    expect_at(f + 78, KY, 276);
    expect_at(f + 79, KON, 1);
    expect_at(f + 79, KY, 240);
    expect_at(f + 79, KFL, 0);
    tick(19);
    bullet_on = 1'b0;
    tick(60);
    bullet_on = 1'b1;
    expect_at(f + 80, KHIT, 1);
    expect_at(f + 81, KFL, 1);
    tick(3);
    bullet_on = 1'b0;
    Reset = 1'b1;
    expect_at(f + 82, KFL, 0);
    expect_at(f + 82, KON, 1);
    expect_at(f + 82, KSC, 0);
    expect_at(f + 82, KY, 240);
    tick(1);
    Reset = 1'b0;
    tick(2);
`else
    // Single hit kills; respawn after 60 frames; reset while dead clears score.
    do_reset();
    f = frame;
    set_bullet(478, 240, 4, 1'b1);
    expect_at(f + 1, KHIT, 1);
    expect_at(f + 1, KON, 0);
    expect_at(f + 1, KSC, 1);
    expect_at(f + 2, KHIT, 0);
    expect_at(f + 60, KON, 0);
    expect_at(f + 60, KY, 240);
    expect_at(f + 61, KON, 1);
    expect_at(f + 61, KHIT, 0);
    expect_at(f + 62, KHIT, 1);
    expect_at(f + 62, KSC, 2);
    expect_at(f + 62, KON, 0);
    expect_at(f + 50, KFL, 0);
    tick(70);
    bullet_on = 1'b0;
    Reset = 1'b1;
    expect_at(f + 70, KON, 1);
    expect_at(f + 70, KSC, 0);
    expect_at(f + 70, KY, 240);
    expect_at(f + 70, KHIT, 0);
    tick(1);
    Reset = 1'b0;
    tick(2);

    // Kill every 61 frames until the score saturates.
    do_reset();
    f = frame;
    set_bullet(478, 240, 4, 1'b1);
    expect_at(f + 15434, KSC, 254);
    expect_at(f + 15495, KSC, 255);
    expect_at(f + 15556, KHIT, 1);
    expect_at(f + 15556, KSC, 255);
    expect_at(f + 15557, KSC, 255);
    tick(15560);
    bullet_on = 1'b0;
    tick(2);
`endif

    drain = 1'b1;
    @(negedge frame_clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
